// File: rtl/jt51_wrfifo.sv
// Buffered YM2151-style write front-end: queues {chip, addr, data} host writes and
// replays them as paced strobes to CHIPS jt51 cores. Optional stats: JT51_WRFIFO_STATS_EN.
module jt51_wrfifo #(
  parameter int DEPTH = 16,
  parameter int CHIPS = 2,
  parameter int CW    = 3,
  parameter int GUARD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cen_p1,
  input  logic                     flush,
  input  logic                     cs_n,
  input  logic                     wr_n,
  input  logic                     a0,
  input  logic [7:0]               din,
  input  logic [CW-1:0]            chip,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CHIPS-1:0]         yc_cs_n,
  output logic                     yc_wr_n,
  output logic                     yc_a0,
  output logic [7:0]               yc_din,
  input  logic [CHIPS-1:0]         yc_busy
`ifdef JT51_WRFIFO_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   hwm
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = CW + 16;
  localparam int NB = 1 << CW;
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);
  localparam logic [CW:0] CHIPS_W    = (CW+1)'(CHIPS);
  localparam logic [7:0]  GUARD_LAST = 8'(GUARD - 1);

  typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GUARDW, WAITB} state_t;

  logic          host_wr, push_req, drop, push, pop, tick;
  logic          full, empty;
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [7:0]    addr_q;
  logic          ovf_q, ovf_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head;
  logic [CW-1:0] head_chip;
  logic [7:0]    head_addr, head_data;
  logic [NB-1:0] busy_ext;
  state_t        state_q;
  logic [7:0]    cnt_q;
  logic [CW-1:0] cur_q;

  function automatic logic [CHIPS-1:0] cs_sel(input logic [CW-1:0] c);
    logic [NB-1:0] oh;
    oh = ~(NB'(1) << c);
    return oh[CHIPS-1:0];
  endfunction

  assign tick      = cen_p1;
  assign host_wr   = !cs_n && !wr_n;
  assign push_req  = host_wr && a0;
  assign level     = wr_q - rd_q;
  assign empty     = (wr_q == rd_q);
  assign full      = (level == LEVEL_FULL);
  assign drop      = push_req && (full || ({1'b0, chip} >= CHIPS_W));
  assign push      = push_req && !drop && !flush;
  assign pop       = (state_q == DATA) && tick && (cnt_q == 8'd1) && !flush;
  assign head      = mem_q[rd_q[AW-1:0]];
  assign head_chip = head[EW-1 -: CW];
  assign head_addr = head[15:8];
  assign head_data = head[7:0];
  assign busy_ext  = NB'(yc_busy);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q | drop;
    if (flush) begin
      rd_d  = wr_q;
      ovf_d = 1'b0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
      if (host_wr && !a0) addr_q <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {chip, addr_q, din};
  end

  // Strobe outputs are registered on state transitions; yc_a0/yc_din are only
  // loaded when a strobe starts, so they stay stable through it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      yc_cs_n <= '1;
      yc_wr_n <= 1'b1;
      yc_a0   <= 1'b0;
      yc_din  <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      yc_cs_n <= '1;
      yc_wr_n <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty && !busy_ext[head_chip]) begin
            state_q <= ADDR;
            cur_q   <= head_chip;
            cnt_q   <= '0;
            yc_cs_n <= cs_sel(head_chip);
            yc_wr_n <= 1'b0;
            yc_a0   <= 1'b0;
            yc_din  <= head_addr;
          end
        end
        ADDR: begin
          if (tick) begin
            if (cnt_q == 8'd1) begin
              state_q <= GAP1;
              cnt_q   <= '0;
              yc_cs_n <= '1;
              yc_wr_n <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        GAP1: begin
          if (tick) begin
            state_q <= DATA;
            yc_cs_n <= cs_sel(cur_q);
            yc_wr_n <= 1'b0;
            yc_a0   <= 1'b1;
            yc_din  <= head_data;
          end
        end
        DATA: begin
          if (tick) begin
            if (cnt_q == 8'd1) begin
              state_q <= (GUARD == 0) ? WAITB : GUARDW;
              cnt_q   <= '0;
              yc_cs_n <= '1;
              yc_wr_n <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        GUARDW: begin
          if (tick) begin
            if (cnt_q == GUARD_LAST) state_q <= WAITB;
            else                     cnt_q   <= cnt_q + 8'd1;
          end
        end
        WAITB: begin
          if (!busy_ext[cur_q]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef JT51_WRFIFO_STATS_EN
  logic [7:0]  drops_q;
  logic [AW:0] hwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drops_q <= '0;
      hwm_q   <= '0;
    end else if (flush) begin
      drops_q <= '0;
      hwm_q   <= '0;
    end else begin
      if (drop && drops_q != 8'hFF) drops_q <= drops_q + 8'd1;
      if (level > hwm_q)            hwm_q   <= level;
    end
  end

  assign hwm  = hwm_q;
  assign dout = (!cs_n && wr_n && a0) ? drops_q : {full, empty, ovf_q, 5'b0};
`else
  assign dout = {full, empty, ovf_q, 5'b0};
`endif

endmodule
